// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the sized data memory: access-size and
// controller state encodings, byte-enable generation and load extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    function automatic logic [3:0] lane_enable(input size_e size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Replicate right-aligned store data across all lanes; the byte enable picks the live one.
    function automatic logic [31:0] store_align(input size_e size, input logic [31:0] wdata);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = {4{wdata[7:0]}};
            SZ_HALF: res = {2{wdata[15:0]}};
            default: res = wdata;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input size_e size,
                                                 input logic [1:0] addr_lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            SZ_WORD: res = word;
            default: res = 32'h00000000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-enabled 32-bit RAM with synchronous write and registered read.
module dmem_bank #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [3:0]       i_be,
    input  logic [IDX_W-1:0] i_index,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Lane-masked write plus read of the addressed word every cycle.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_index][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        r_rdata <= r_mem[i_index];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_sized.sv
// MEM-stage data memory: byte/half/word loads and stores behind a valid/ready
// request port with a configurable number of wait states.
module data_mem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_busy
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e           r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic             r_we, r_uns;
    size_e            r_size;
    logic [IDX_W+1:0] r_addr;
    logic [31:0]      r_wdata;
    logic             r_req_ready, r_busy, r_resp_valid, r_resp_err;
    logic [31:0]      r_resp_rdata;

    logic             w_accept, w_err_in, w_bank_we, w_unused_addr;
    logic [IDX_W-1:0] w_index;
    logic [31:0]      w_bank_rdata;

    assign w_accept      = (r_state == ST_IDLE) && i_req_valid;
    assign w_err_in      = is_misaligned(size_e'(i_req_size), i_req_addr[1:0]);
    assign w_unused_addr = ^i_req_addr[31:IDX_W+2];

    // While idle the bank reads the incoming address so the word is ready by ACCESS.
    assign w_index   = (r_state == ST_IDLE) ? i_req_addr[IDX_W+1:2] : r_addr[IDX_W+1:2];
    assign w_bank_we = (r_state == ST_ACCESS) && r_we && !i_reset;

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .i_clk   (i_clk),
        .i_we    (w_bank_we),
        .i_be    (lane_enable(r_size, r_addr[1:0])),
        .i_index (w_index),
        .i_wdata (store_align(r_size, r_wdata)),
        .o_rdata (w_bank_rdata)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!i_req_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_err_in) begin
                    w_state_nxt = ST_RESP;
                end else if (WAIT_CYCLES == 0) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State, request latch and registered handshake/response outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_size       <= SZ_BYTE;
            r_addr       <= '0;
            r_wdata      <= 32'h00000000;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h00000000;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_req_ready  <= (w_state_nxt == ST_IDLE);
            r_busy       <= (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_ACCESS);
            r_resp_valid <= (w_state_nxt == ST_RESP);
            if (w_accept) begin
                r_we    <= i_req_we;
                r_uns   <= i_req_unsigned;
                r_size  <= size_e'(i_req_size);
                r_addr  <= i_req_addr[IDX_W+1:0];
                r_wdata <= i_req_wdata;
            end
            if (r_state == ST_ACCESS) begin
                r_resp_rdata <= r_we ? 32'h00000000
                                     : load_extract(w_bank_rdata, r_size, r_addr[1:0], r_uns);
                r_resp_err   <= 1'b0;
            end else if (w_accept && w_err_in) begin
                r_resp_rdata <= 32'h00000000;
                r_resp_err   <= 1'b1;
            end else if (r_state == ST_RESP) begin
                r_resp_rdata <= 32'h00000000;
                r_resp_err   <= 1'b0;
            end
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_busy       = r_busy;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

endmodule

// File: doc/data_mem_sized.md
Name: data_mem_sized

Overview:
- Parametrised successor to the single-cycle word data memory.
- Byte-addressed, configurable depth.
- Supports MIPS load/store sizes (byte, half, word) with sign or zero extension and misalignment detection.
- Exposes a valid/ready request interface with configurable wait states, so the pipeline can stall on memory.
- Sits in the MEM stage between the ALU result / store-data path and the writeback mux.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; power of two, ≥ 2.
- WAIT_CYCLES, 0, extra cycles between request acceptance and access commit; 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size, encoding from package.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved-size request; valid with resp_valid.
- busy  out  1  request accepted and not yet responded (stall to hazard unit).

Behaviour:
- Reset (sync, active-high): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, wait counter=0. Memory contents are not cleared by reset; they are zero at time 0.
- Indexing: word index = req_addr[2 +: log2(DEPTH_WORDS)]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Lane order is little-endian: addr[1:0]=0 selects bits [7:0]; a half at addr[1]=0 selects bits [15:0].
- Acceptance: at a rising edge with state=IDLE and req_valid=1. All req_* fields are latched; the inputs may change afterwards.
- Alignment check at acceptance:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - req_size=11 (reserved) is always an error.
- FSM states:
  - IDLE: req_ready=1, busy=0.
    - Accept with error → RESP; no memory change.
    - Accept with WAIT_CYCLES=0 → ACCESS.
    - Accept with WAIT_CYCLES>0 → WAIT, counter loaded with WAIT_CYCLES-1.
  - WAIT: req_ready=0, busy=1. Counter decrements each edge; at 0 → ACCESS.
  - ACCESS: req_ready=0, busy=1.
    - On the edge leaving ACCESS, stores commit only the selected byte lanes (other lanes unchanged); loads capture and extend the selected lanes into resp_rdata.
    - Next state is RESP.
  - RESP: resp_valid=1 for exactly one cycle, busy=0, req_ready=0 → IDLE.
- Latency: resp_valid asserts WAIT_CYCLES+2 cycles after the acceptance edge; errors assert 1 cycle after it. Throughput is one request per WAIT_CYCLES+3 cycles.
- Stores: resp_rdata=0 and resp_err=0 in RESP (acknowledge only).
- Errors: resp_err=1 and resp_rdata=0; no memory write.
- No response backpressure; the consumer must sample resp_valid when it is high.
- Reset mid-operation: an uncommitted store is dropped. Reset applies the reset values at the next edge; no resp_valid is produced for the aborted request.
- req_valid while not IDLE is ignored. The requester holds the request until it sees req_ready=1 at an edge.
- Extension rules: byte load sign-extends bit 7 unless req_unsigned; half load sign-extends bit 15 unless req_unsigned; for word loads req_unsigned has no effect.

Decomposition:
- Package dmem_pkg holds:
  - size enum: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11.
  - FSM state enum (IDLE, WAIT, ACCESS, RESP).
  - function for lane-enable generation: size + addr[1:0] → 4-bit byte enable.
  - function for load extraction/extension.
- One sub-module: dmem_bank, a byte-enabled synchronous 32-bit RAM (clk, we, be[3:0], index, wdata, rdata). The controller FSM lives in data_mem_sized.

Test Plan:
- WAIT_CYCLES=0: store word 0xDEADBEEF at 0x08, then load word at 0x08 → resp_valid 2 cycles after each acceptance, resp_rdata=0xDEADBEEF, resp_err=0.
- Store byte 0x80 at 0x09 over 0xDEADBEEF:
  - signed byte load at 0x09 → 0xFFFFFF80.
  - unsigned byte load at 0x09 → 0x00000080.
  - word load at 0x08 → 0xDEAD80EF.
- Half store 0x1234 at 0x0E, then signed half load at 0x0E → 0x00001234. Half load at 0x0D and word load at 0x0A → resp_err=1, resp_rdata=0, 1 cycle after acceptance, memory unchanged.
- WAIT_CYCLES=3: load accepted at edge T → busy=1 and req_ready=0 through T+4, resp_valid exactly at cycle T+5; req_valid held high meanwhile is not accepted until IDLE.
- DEPTH_WORDS=64: store 0x55 (word) at 0x100, load at 0x000 → 0x00000055 (wrap).
- WAIT_CYCLES=3: assert reset 2 cycles after a store of 0xAAAAAAAA to 0x04 is accepted → no resp_valid. Later load at 0x04 returns its prior value; outputs are at reset values after the reset edge.
